// File: rtl/router_pkg.sv
// Shared constants for the router data path: header field layout, reader FSM states
// and the starvation window that the router's soft-reset logic also uses.
package router_pkg;
  localparam int DATA_W         = 8;
  localparam int ADDR_LSB       = 0;
  localparam int ADDR_W         = 2;
  localparam int LEN_LSB        = 2;
  localparam int LEN_W          = 6;
  localparam int TIMEOUT_CYCLES = 30;

  typedef enum logic [1:0] {HDR, PAY, PAR} rd_state_e;
endpackage

// File: rtl/router_pkt_reader_if.sv
// Router output port (vld_out/read_enb/data_in) plus the re-framed byte stream.
// master = packet reader, slave = router FIFO together with the downstream consumer.
interface router_pkt_reader_if #(
  parameter int DATA_W = router_pkg::DATA_W
);
  logic              vld_out;
  logic              read_enb;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sop;
  logic              m_eop;

  modport master (
    input  vld_out, data_in, m_ready,
    output read_enb, m_data, m_valid, m_sop, m_eop
  );
  modport slave (
    output vld_out, data_in, m_ready,
    input  read_enb, m_data, m_valid, m_sop, m_eop
  );
endinterface

// File: rtl/router_skid_buf.sv
// Circular buffer of {sop, eop, data} entries with registered head and a one-cycle flush.
module router_skid_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              push_sop,
  input  logic              push_eop,
  input  logic [DATA_W-1:0] push_data,
  output logic [OCC_W-1:0]  occ,
  output logic              head_sop,
  output logic              head_eop,
  output logic [DATA_W-1:0] head_data
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W+1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_sop, push_eop, push_data};
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign {head_sop, head_eop, head_data} = mem[rd_ptr];
endmodule

// File: rtl/router_pkt_reader.sv
// Drains one router output FIFO, re-frames packets as a sop/eop stream, checks parity
// and aborts on starvation.
//   state | meaning
//   HDR   | next captured byte is a header
//   PAY   | capturing payload, remaining bytes counted down
//   PAR   | next captured byte is the parity byte
module router_pkt_reader #(
  parameter int DATA_W         = router_pkg::DATA_W,
  parameter int SKID_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = router_pkg::TIMEOUT_CYCLES
) (
  input  logic                          clock,
  input  logic                          resetn,
  router_pkt_reader_if.master           bus,
  output logic [router_pkg::ADDR_W-1:0] pkt_addr,
  output logic [router_pkg::LEN_W-1:0]  pkt_len,
  output logic                          pkt_done,
  output logic                          parity_err,
  output logic                          timeout_err
);
  import router_pkg::*;

  localparam int OCC_W = $clog2(SKID_DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OCC_W:0]  DEPTH_V = SKID_DEPTH[OCC_W:0];
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  rd_state_e         state_q, state_d;
  logic              rd_q;
  logic [1:0]        abort_cnt;
  logic              abort_q;
  logic [TO_W-1:0]   to_cnt;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] acc;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    fill;
  logic              cap, blocked, abort_now, pop;
  logic              head_sop, head_eop;
  logic [DATA_W-1:0] head_data;
  logic [LEN_W-1:0]  hdr_len;

  // Bytes held plus the byte landing now; never let that exceed the skid depth.
  assign fill         = {1'b0, occ} + {{OCC_W{1'b0}}, rd_q};
  assign abort_q      = (abort_cnt != 2'd0);
  assign bus.read_enb = bus.vld_out && (fill < DEPTH_V) && !abort_q;
  assign cap          = rd_q;
  assign blocked      = bus.vld_out && !bus.read_enb;
  assign abort_now    = blocked && (to_cnt == TO_LAST);
  assign hdr_len      = bus.data_in[LEN_LSB +: LEN_W];
  assign bus.m_valid  = (occ != '0);
  assign pop          = bus.m_valid && bus.m_ready;
  assign bus.m_data   = head_data;
  assign bus.m_sop    = head_sop;
  assign bus.m_eop    = head_eop;

  router_skid_buf #(.DATA_W(DATA_W), .DEPTH(SKID_DEPTH)) u_skid (
    .clock     (clock),
    .resetn    (resetn),
    .push      (cap),
    .pop       (pop),
    .flush     (abort_now),
    .push_sop  (state_q == HDR),
    .push_eop  (state_q == PAR),
    .push_data (bus.data_in),
    .occ       (occ),
    .head_sop  (head_sop),
    .head_eop  (head_eop),
    .head_data (head_data)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= HDR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_now) begin
      state_d = HDR;
    end else if (cap) begin
      unique case (state_q)
        HDR:     state_d = (hdr_len == '0) ? PAR : PAY;
        PAY:     if (remaining == LEN_W'(1)) state_d = PAR;
        PAR:     state_d = HDR;
        default: state_d = HDR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_q        <= 1'b0;
      abort_cnt   <= 2'd0;
      to_cnt      <= '0;
      remaining   <= '0;
      acc         <= '0;
      pkt_addr    <= '0;
      pkt_len     <= '0;
      pkt_done    <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rd_q        <= bus.read_enb;
      pkt_done    <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= abort_now;
      if (abort_now) begin
        // Hold off reads while the router soft-resets its FIFO.
        abort_cnt <= 2'd2;
        to_cnt    <= '0;
        acc       <= '0;
      end else begin
        if (abort_q) abort_cnt <= abort_cnt - 2'd1;
        to_cnt <= blocked ? to_cnt + TO_W'(1) : '0;
        if (cap) begin
          unique case (state_q)
            HDR: begin
              pkt_len   <= hdr_len;
              pkt_addr  <= bus.data_in[ADDR_LSB +: ADDR_W];
              acc       <= bus.data_in;
              remaining <= hdr_len;
            end
            PAY: begin
              acc       <= acc ^ bus.data_in;
              remaining <= remaining - LEN_W'(1);
            end
            PAR: begin
              pkt_done   <= 1'b1;
              parity_err <= (acc != bus.data_in);
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule
